// File: rtl/lock_attempt_ctrl.sv
// Sequencing controller for the 3-digit keypad lock: owns LOCK, counts failed
// OPEN attempts and enforces a timed lockout. Optional macro: LOCK_AUTO_RELOCK_EN.
module lock_attempt_ctrl #(
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 1000,
  parameter int RELOCK_CYCLES  = 5000,
  parameter int CNT_W          = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       OPEN,
  input  logic       CLOSE,
  input  logic       EQ,
  input  logic       KEY_P,
  output logic       LOCK,
  output logic       LOCKOUT,
  output logic       KEY_EN,
  output logic       CLR_DIGITS,
  output logic [3:0] FAIL_CNT,
  output logic [1:0] state_dbg
);

  // Handshake: there is no valid/ready pair here; OPEN and CLOSE are levels
  // sampled every rising CLK, KEY_P is a single-cycle strobe, EQ is valid
  // every cycle, and every output is a register updated one edge after sampling.

  typedef enum logic [1:0] {
    S_CLOSED     = 2'd0,
    S_OPENED     = 2'd1,
    S_LOCKED_OUT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LOCKOUT_LOAD = CNT_W'(LOCKOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RELOCK_LOAD  = CNT_W'(RELOCK_CYCLES - 1);
  localparam logic [3:0]       MAX_CNT      = 4'(MAX_TRIES);

  state_t           state;
  logic [CNT_W-1:0] timer;
  logic             open_q;
  logic             attempt;
  logic [3:0]       fail_inc;
  logic             clr_ok;

  assign attempt   = OPEN & ~open_q;
  assign fail_inc  = FAIL_CNT + 4'd1;
  // A clear request directly after a pulse is absorbed so pulses never touch.
  assign clr_ok    = ~CLR_DIGITS;
  assign state_dbg = state;

`ifndef LOCK_AUTO_RELOCK_EN
  logic unused_key_p;
  assign unused_key_p = KEY_P;
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= S_CLOSED;
      LOCK       <= 1'b0;
      LOCKOUT    <= 1'b0;
      KEY_EN     <= 1'b1;
      CLR_DIGITS <= 1'b0;
      FAIL_CNT   <= 4'd0;
      timer      <= '0;
      open_q     <= 1'b0;
    end else begin
      open_q     <= OPEN;
      CLR_DIGITS <= 1'b0;
      case (state)
        S_CLOSED: begin
          if (CLOSE) begin
            CLR_DIGITS <= clr_ok;
          end else if (attempt) begin
            if (EQ) begin
              state    <= S_OPENED;
              LOCK     <= 1'b1;
              FAIL_CNT <= 4'd0;
              timer    <= RELOCK_LOAD;
            end else begin
              CLR_DIGITS <= clr_ok;
              if (fail_inc >= MAX_CNT) begin
                state    <= S_LOCKED_OUT;
                LOCKOUT  <= 1'b1;
                KEY_EN   <= 1'b0;
                FAIL_CNT <= MAX_CNT;
                timer    <= LOCKOUT_LOAD;
              end else begin
                FAIL_CNT <= fail_inc;
              end
            end
          end
        end
        S_OPENED: begin
          if (CLOSE) begin
            state      <= S_CLOSED;
            LOCK       <= 1'b0;
            CLR_DIGITS <= clr_ok;
          end
`ifdef LOCK_AUTO_RELOCK_EN
          // Any keypad activity or new OPEN press restarts the idle window.
          else if (attempt || KEY_P) begin
            timer <= RELOCK_LOAD;
          end else if (timer == '0) begin
            state      <= S_CLOSED;
            LOCK       <= 1'b0;
            CLR_DIGITS <= clr_ok;
          end else begin
            timer <= timer - 1'b1;
          end
`endif
        end
        S_LOCKED_OUT: begin
          if (timer == '0) begin
            state      <= S_CLOSED;
            LOCKOUT    <= 1'b0;
            KEY_EN     <= 1'b1;
            FAIL_CNT   <= 4'd0;
            CLR_DIGITS <= clr_ok;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: begin
          state <= S_CLOSED;
          LOCK  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/lock_attempt_ctrl.md
Name: lock_attempt_ctrl

Overview:
- Sequencing controller for the 3-digit keypad lock datapath.
- Takes the password-compare result (EQ), the OPEN/CLOSE buttons and the key-press strobe, and owns the LOCK output.
- Counts failed unlock attempts and enforces a timed lockout after MAX_TRIES consecutive failures.
- Drives digit-clear and keypad-enable controls back to the digit-entry datapath, which no longer drives LOCK itself.

Parameters:
- MAX_TRIES, 3: consecutive failed OPEN attempts that trigger lockout; legal range 1..15.
- LOCKOUT_CYCLES, 1000: CLK cycles spent in lockout; must be >= 1.
- RELOCK_CYCLES, 5000: idle CLK cycles in OPENED before automatic relock; used only with AUTO_RELOCK_EN.
- CNT_W, 16: timer width; must satisfy 2^CNT_W > max(LOCKOUT_CYCLES, RELOCK_CYCLES).

Ports:
- CLK  input  1  system clock, rising-edge.
- RESET  input  1  asynchronous, active-low reset.
- OPEN  input  1  open button, level; synchronous to CLK.
- CLOSE  input  1  close button, level; synchronous to CLK.
- EQ  input  1  entered digits equal stored password; valid every cycle.
- KEY_P  input  1  one-cycle pulse on each new keypad press.
- LOCK  output  1  1 = lock open (same meaning as the existing LOCK signal).
- LOCKOUT  output  1  1 while in the lockout state.
- KEY_EN  output  1  keypad digit capture permitted; 0 in lockout.
- CLR_DIGITS  output  1  one-cycle pulse: datapath clears digit1..3 and returns its entry state to DIGIT_1.
- FAIL_CNT  output  4  current consecutive-failure count.

Behaviour:
- Reset (RESET=0, asynchronous): state=CLOSED, LOCK=0, LOCKOUT=0, KEY_EN=1, CLR_DIGITS=0, FAIL_CNT=0, timer=0, open_q=0.
- All outputs are registered.
- OPEN edge detection: open_q <= OPEN every cycle. An attempt is OPEN & ~open_q. Holding OPEN high counts as a single attempt.
- States: CLOSED, OPENED, LOCKED_OUT.
- CLOSED:
  - Attempt with EQ=1: next cycle state=OPENED, LOCK=1, FAIL_CNT=0; relock timer loads RELOCK_CYCLES-1.
  - Attempt with EQ=0: FAIL_CNT+1 and a CLR_DIGITS pulse.
  - If FAIL_CNT+1 == MAX_TRIES, go instead to LOCKED_OUT: LOCKOUT=1, KEY_EN=0, timer loads LOCKOUT_CYCLES-1, FAIL_CNT holds MAX_TRIES.
  - CLOSE in CLOSED: CLR_DIGITS pulse only; FAIL_CNT unchanged.
- OPENED:
  - CLOSE=1: next cycle state=CLOSED, LOCK=0, CLR_DIGITS pulse.
  - Further OPEN attempts are ignored.
- LOCKED_OUT:
  - OPEN and CLOSE are ignored; KEY_P is ignored.
  - Timer decrements by 1 per cycle. On the cycle the timer is 0: next state=CLOSED, LOCKOUT=0, KEY_EN=1, FAIL_CNT=0, CLR_DIGITS pulse.
  - Total lockout duration is exactly LOCKOUT_CYCLES cycles.
- Simultaneous events:
  - CLOSE and an attempt in the same cycle: CLOSE wins, attempt discarded, no failure counted.
  - OPEN already held high when lockout ends: no attempt until OPEN is released and re-pressed.
- Latency: every decision appears on outputs exactly 1 cycle after the sampling edge.
- CLR_DIGITS is high for exactly one cycle per event and never asserted in two consecutive cycles.
- FAIL_CNT saturates at MAX_TRIES and never wraps.
- Reset asserted mid-lockout or while OPENED: immediate return to reset values; no CLR_DIGITS pulse is generated.

Optional Feature:
- Macro: LOCK_AUTO_RELOCK_EN.
- Defined:
  - In OPENED, the timer decrements each cycle and reloads RELOCK_CYCLES-1 on any KEY_P or on a rising OPEN edge.
  - When the timer reaches 0 with no CLOSE: state=CLOSED, LOCK=0, CLR_DIGITS pulse, identical to a CLOSE.
  - CLOSE in the expiry cycle behaves as a single close; only one CLR_DIGITS pulse.
- Not defined: no relock logic; OPENED persists until CLOSE or reset; RELOCK_CYCLES unused.

Test Plan (MAX_TRIES=3, LOCKOUT_CYCLES=8, RELOCK_CYCLES=16):
1. Reset release, EQ=1, pulse OPEN 1 cycle -> LOCK=1 one cycle later, FAIL_CNT=0; CLOSE -> LOCK=0 plus one CLR_DIGITS pulse.
2. EQ=0, three separate OPEN presses -> FAIL_CNT 1, 2, then LOCKOUT=1, KEY_EN=0, CLR_DIGITS pulsed each time; exactly 8 cycles later LOCKOUT=0, KEY_EN=1, FAIL_CNT=0.
3. During lockout: EQ=1 and OPEN pressed -> LOCK stays 0, timer is not extended. OPEN held across lockout exit -> no attempt until released and re-pressed.
4. EQ=0, OPEN held high 20 cycles -> FAIL_CNT=1 only. Then OPEN and CLOSE asserted in the same cycle -> FAIL_CNT stays 1, one CLR_DIGITS pulse.
5. RESET driven low asynchronously mid-lockout, between clock edges -> LOCKOUT=0, FAIL_CNT=0, LOCK=0 immediately, without waiting for CLK.
6. LOCK_AUTO_RELOCK_EN: open, KEY_P at cycle 10 -> relock at cycle 10+16; with no KEY_P -> LOCK=0 exactly 16 cycles after opening. Without the macro, LOCK stays 1 for 100 cycles.
